// File: rtl/i2c_reg_target.sv
`default_nettype none
// ============================================================================
// Module   : i2c_reg_target
// Purpose  : I2C target with a 7-bit device address and a 16-bit register
//            pointer. Received data bytes become one-clk write strobes.
//            Read bytes come from a register-file port. The pointer
//            auto-increments after every data byte.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_reg_target #(
  parameter logic [6:0] DEV_ID = 7'h35
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  output logic        wr_valid,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic [15:0] rd_addr,
  input  logic [7:0]  rd_data,
  output logic        busy
);

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_DEV_ADDR = 4'd1;
  localparam logic [3:0] ST_ACK_DEV  = 4'd2;
  localparam logic [3:0] ST_PTR_HI   = 4'd3;
  localparam logic [3:0] ST_ACK_HI   = 4'd4;
  localparam logic [3:0] ST_PTR_LO   = 4'd5;
  localparam logic [3:0] ST_ACK_LO   = 4'd6;
  localparam logic [3:0] ST_WDATA    = 4'd7;
  localparam logic [3:0] ST_ACK_W    = 4'd8;
  localparam logic [3:0] ST_RDATA    = 4'd9;
  localparam logic [3:0] ST_ACK_R    = 4'd10;
  localparam logic [3:0] ST_IGNORE   = 4'd11;

  // Pin synchronizers plus one history stage each for edge detection
  logic scl_s1_q, scl_s1_d, scl_s2_q, scl_s2_d, scl_h_q, scl_h_d;
  logic sda_s1_q, sda_s1_d, sda_s2_q, sda_s2_d, sda_h_q, sda_h_d;
  // Registered bus events; the FSM acts on these
  logic start_q, start_d, stop_q, stop_d;
  logic rise_q, rise_d, fall_q, fall_d, bit_q, bit_d;
  // Protocol state
  logic [3:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  sr_q, sr_d;
  logic [6:0]  tx_q, tx_d;
  logic [15:0] ptr_q, ptr_d;
  logic        rw_q, rw_d;
  logic        nack_q, nack_d;
  // Registered outputs
  logic        sda_oe_q, sda_oe_d;
  logic        wr_valid_q, wr_valid_d;
  logic [15:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;

  logic wr_byte_done;
  logic scl_rise, scl_fall, sda_rise, sda_fall, scl_edge;

  // Synchronizer shifting and START/STOP/SCL-edge decoding
  always_comb begin
    scl_s1_d = scl_i;
    scl_s2_d = scl_s1_q;
    scl_h_d  = scl_s2_q;
    sda_s1_d = sda_i;
    sda_s2_d = sda_s1_q;
    sda_h_d  = sda_s2_q;
    scl_rise = scl_s2_q & ~scl_h_q;
    scl_fall = ~scl_s2_q & scl_h_q;
    sda_rise = sda_s2_q & ~sda_h_q;
    sda_fall = ~sda_s2_q & sda_h_q;
    scl_edge = scl_rise | scl_fall;
    // A simultaneous SCL edge means the SDA change is data, not a condition
    start_d  = sda_fall & scl_s2_q & ~scl_edge;
    stop_d   = sda_rise & scl_s2_q & ~scl_edge;
    rise_d   = scl_rise;
    fall_d   = scl_fall;
    bit_d    = sda_s2_q;
  end

  assign wr_byte_done = ~start_q & ~stop_q & rise_q &
                        (state_q == ST_WDATA) & (cnt_q == 4'd7);

  // State register: every flop of the block
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_s1_q   <= 1'b1;
      scl_s2_q   <= 1'b1;
      scl_h_q    <= 1'b1;
      sda_s1_q   <= 1'b1;
      sda_s2_q   <= 1'b1;
      sda_h_q    <= 1'b1;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      bit_q      <= 1'b1;
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      sr_q       <= 8'd0;
      tx_q       <= 7'd0;
      ptr_q      <= 16'd0;
      rw_q       <= 1'b0;
      nack_q     <= 1'b0;
      sda_oe_q   <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= 16'd0;
      wr_data_q  <= 8'd0;
    end else begin
      scl_s1_q   <= scl_s1_d;
      scl_s2_q   <= scl_s2_d;
      scl_h_q    <= scl_h_d;
      sda_s1_q   <= sda_s1_d;
      sda_s2_q   <= sda_s2_d;
      sda_h_q    <= sda_h_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      bit_q      <= bit_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      tx_q       <= tx_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      nack_q     <= nack_d;
      sda_oe_q   <= sda_oe_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Next-state logic: byte shifting, pointer updates, protocol sequencing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    tx_d    = tx_q;
    ptr_d   = ptr_q;
    rw_d    = rw_q;
    nack_d  = nack_q;
    if (stop_q) begin
      state_d = ST_IDLE;
      cnt_d   = 4'd0;
    end else if (start_q) begin
      state_d = ST_DEV_ADDR;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        ST_DEV_ADDR, ST_PTR_HI, ST_PTR_LO, ST_WDATA: begin
          if (rise_q && cnt_q != 4'd8) begin
            sr_d  = {sr_q[6:0], bit_q};
            cnt_d = cnt_q + 4'd1;
          end
          if (wr_byte_done) begin
            ptr_d = ptr_q + 16'd1;
          end
          // The falling edge after the 8th bit opens the ACK slot
          if (fall_q && cnt_q == 4'd8) begin
            cnt_d = 4'd0;
            case (state_q)
              ST_DEV_ADDR: begin
                if (sr_q[7:1] == DEV_ID) begin
                  state_d = ST_ACK_DEV;
                  rw_d    = sr_q[0];
                end else begin
                  state_d = ST_IGNORE;
                end
              end
              ST_PTR_HI: begin
                ptr_d[15:8] = sr_q;
                state_d     = ST_ACK_HI;
              end
              ST_PTR_LO: begin
                ptr_d[7:0] = sr_q;
                state_d    = ST_ACK_LO;
              end
              default: state_d = ST_ACK_W;
            endcase
          end
        end
        ST_ACK_DEV: begin
          if (fall_q) begin
            if (rw_q) begin
              state_d = ST_RDATA;
              tx_d    = rd_data[6:0];
            end else begin
              state_d = ST_PTR_HI;
            end
          end
        end
        ST_ACK_HI: begin
          if (fall_q) state_d = ST_PTR_LO;
        end
        ST_ACK_LO, ST_ACK_W: begin
          if (fall_q) state_d = ST_WDATA;
        end
        ST_RDATA: begin
          if (rise_q && cnt_q != 4'd8) begin
            cnt_d = cnt_q + 4'd1;
          end
          if (fall_q) begin
            if (cnt_q == 4'd8) begin
              state_d = ST_ACK_R;
              cnt_d   = 4'd0;
              ptr_d   = ptr_q + 16'd1;
            end else begin
              tx_d = {tx_q[5:0], 1'b0};
            end
          end
        end
        ST_ACK_R: begin
          if (rise_q) nack_d = bit_q;
          if (fall_q) begin
            if (nack_q) begin
              state_d = ST_IGNORE;
            end else begin
              state_d = ST_RDATA;
              tx_d    = rd_data[6:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Output logic: SDA drive only moves on SCL falling edges, write strobe
  always_comb begin
    sda_oe_d   = sda_oe_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    if (start_q || stop_q) begin
      sda_oe_d = 1'b0;
    end else if (fall_q) begin
      case (state_d)
        ST_ACK_DEV, ST_ACK_HI, ST_ACK_LO, ST_ACK_W: sda_oe_d = 1'b1;
        // First bit of a byte comes straight from rd_data, later ones from tx
        ST_RDATA: sda_oe_d = (state_q == ST_RDATA) ? ~tx_q[6] : ~rd_data[7];
        default:  sda_oe_d = 1'b0;
      endcase
    end
    if (wr_byte_done) begin
      wr_valid_d = 1'b1;
      wr_addr_d  = ptr_q;
      wr_data_d  = {sr_q[6:0], bit_q};
    end
  end

  assign sda_oe   = sda_oe_q;
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign rd_addr  = ptr_q;
  assign busy     = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_i2c_reg_target.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_i2c_reg_target
// Purpose  : Bus-level master model driving i2c_reg_target, with a write
//            scoreboard and a register-file read model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_reg_target;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m_scl = 1'b1;
  logic        m_sda = 1'b1;
  logic        sda_line;
  logic        sda_oe, wr_valid, busy;
  logic [15:0] wr_addr, rd_addr;
  logic [7:0]  wr_data, rd_data;

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] rd_exp_q[$];
  int total = 0;
  int bad = 0;
  int hp = 10;
  int q = 6;
  int wr_cnt = 0;
  int oe_cnt = 0;
  logic wv_prev = 1'b0;

  // Open-drain bus: either side may pull SDA low
  assign sda_line = m_sda & ~sda_oe;
  // Register-file model
  assign rd_data  = ~rd_addr[7:0];

  always #5 clk = ~clk;

  i2c_reg_target #(.DEV_ID(7'h35)) dut (
    .clk      (clk),
    .reset    (reset),
    .scl_i    (m_scl),
    .sda_i    (sda_line),
    .sda_oe   (sda_oe),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Write monitor: every strobe must be one clk wide and match the scoreboard
  always @(negedge clk) begin
    wv_prev <= wr_valid;
    if (sda_oe) oe_cnt <= oe_cnt + 1;
    if (wr_valid) begin
      wr_cnt <= wr_cnt + 1;
      check("wr_pulse_width", {31'b0, wv_prev}, 32'd0);
      check("wr_expected", {31'b0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        check("wr_addr", {16'b0, wr_addr}, {16'b0, exp_q[0].a});
        check("wr_data", {24'b0, wr_data}, {24'b0, exp_q[0].d});
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1;
    cyc(q);
    m_scl = 1'b1;
    cyc(hp);
    m_sda = 1'b0;
    cyc(hp);
    m_scl = 1'b0;
  endtask

  task automatic i2c_stop();
    cyc(q);
    m_sda = 1'b0;
    cyc(hp - q);
    m_scl = 1'b1;
    cyc(hp);
    m_sda = 1'b1;
    cyc(hp);
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      cyc(q);
      m_sda = v[7-i];
      cyc(hp - q);
      m_scl = 1'b1;
      cyc(hp);
      m_scl = 1'b0;
    end
  endtask

  task automatic write_byte(input logic [7:0] v, input logic exp_ack, input string tag);
    logic ack;
    send_bits(v, 8);
    cyc(q);
    m_sda = 1'b1;
    cyc(hp - q);
    m_scl = 1'b1;
    cyc(hp - 1);
    ack = ~sda_line;
    cyc(1);
    m_scl = 1'b0;
    check(tag, {31'b0, ack}, {31'b0, exp_ack});
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      cyc(q);
      m_sda = 1'b1;
      cyc(hp - q);
      m_scl = 1'b1;
      cyc(hp - 1);
      b[7-i] = sda_line;
      cyc(1);
      m_scl = 1'b0;
    end
    cyc(q);
    m_sda = ~mack;
    cyc(hp - q);
    m_scl = 1'b1;
    cyc(hp);
    m_scl = 1'b0;
  endtask

  task automatic write_reg(input logic [15:0] ptr, input logic [7:0] data);
    wr_t e;
    i2c_start();
    write_byte(8'h6A, 1'b1, "ack_dev");
    write_byte(ptr[15:8], 1'b1, "ack_ptr_hi");
    write_byte(ptr[7:0], 1'b1, "ack_ptr_lo");
    e.a = ptr;
    e.d = data;
    exp_q.push_back(e);
    write_byte(data, 1'b1, "ack_data");
    i2c_stop();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          w0, o0;
    logic [7:0]  b;
    logic [15:0] p;
    wr_t         e;
    logic [31:0] r;

    cyc(5);
    reset = 1'b0;
    cyc(1);
    check("rst_sda_oe", {31'b0, sda_oe}, 32'd0);
    check("rst_wr_valid", {31'b0, wr_valid}, 32'd0);
    check("rst_wr_addr", {16'b0, wr_addr}, 32'd0);
    check("rst_wr_data", {24'b0, wr_data}, 32'd0);
    check("rst_rd_addr", {16'b0, rd_addr}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);

    // Plain two-byte write with pointer auto-increment
    i2c_start();
    write_byte(8'h6A, 1'b1, "t1_ack_dev");
    check("t1_busy", {31'b0, busy}, 32'd1);
    write_byte(8'h30, 1'b1, "t1_ack_hi");
    write_byte(8'h12, 1'b1, "t1_ack_lo");
    e = '{a: 16'h3012, d: 8'hA5};
    exp_q.push_back(e);
    write_byte(8'hA5, 1'b1, "t1_ack_d0");
    e = '{a: 16'h3013, d: 8'h5A};
    exp_q.push_back(e);
    write_byte(8'h5A, 1'b1, "t1_ack_d1");
    i2c_stop();
    cyc(10);
    check("t1_rd_addr", {16'b0, rd_addr}, 32'h3014);
    check("t1_busy_after", {31'b0, busy}, 32'd0);
    check("t1_q_empty", exp_q.size(), 32'd0);

    // Foreign device address: no ACK, no strobes, pointer untouched
    w0 = wr_cnt;
    o0 = oe_cnt;
    i2c_start();
    write_byte(8'h6C, 1'b0, "t2_nack_dev");
    write_byte(8'h30, 1'b0, "t2_nack_b0");
    write_byte(8'h00, 1'b0, "t2_nack_b1");
    write_byte(8'h77, 1'b0, "t2_nack_b2");
    i2c_stop();
    cyc(10);
    check("t2_no_drive", oe_cnt - o0, 32'd0);
    check("t2_no_wr", wr_cnt - w0, 32'd0);
    check("t2_rd_addr", {16'b0, rd_addr}, 32'h3014);

    // Random read across the pointer wrap
    i2c_start();
    write_byte(8'h6A, 1'b1, "t3_ack_dev_w");
    write_byte(8'hFF, 1'b1, "t3_ack_hi");
    write_byte(8'hFF, 1'b1, "t3_ack_lo");
    i2c_start();
    write_byte(8'h6B, 1'b1, "t3_ack_dev_r");
    p = 16'hFFFF;
    rd_exp_q.push_back(~p[7:0]);
    p = p + 16'd1;
    rd_exp_q.push_back(~p[7:0]);
    read_byte(1'b1, b);
    check("t3_rd_byte0", {24'b0, b}, {24'b0, rd_exp_q.pop_front()});
    read_byte(1'b0, b);
    check("t3_rd_byte1", {24'b0, b}, {24'b0, rd_exp_q.pop_front()});
    i2c_stop();
    cyc(10);
    check("t3_rd_addr", {16'b0, rd_addr}, 32'h0001);
    check("t3_busy_after", {31'b0, busy}, 32'd0);

    // STOP in the middle of a data byte, then a fresh write
    w0 = wr_cnt;
    i2c_start();
    write_byte(8'h6A, 1'b1, "t4_ack_dev");
    write_byte(8'h00, 1'b1, "t4_ack_hi");
    write_byte(8'h40, 1'b1, "t4_ack_lo");
    send_bits(8'hB0, 4);
    i2c_stop();
    cyc(10);
    check("t4_no_partial_wr", wr_cnt - w0, 32'd0);
    write_reg(16'h0001, 8'h11);
    cyc(10);
    check("t4_single_wr", wr_cnt - w0, 32'd1);
    check("t4_q_empty", exp_q.size(), 32'd0);

    // Reset while the target holds its address ACK low
    i2c_start();
    send_bits(8'h6A, 8);
    cyc(q);
    m_sda = 1'b1;
    cyc(hp - q);
    m_scl = 1'b1;
    cyc(2);
    check("t5_ack_driven", {31'b0, sda_oe}, 32'd1);
    reset = 1'b1;
    cyc(1);
    check("t5_sda_released", {31'b0, sda_oe}, 32'd0);
    check("t5_busy", {31'b0, busy}, 32'd0);
    reset = 1'b0;
    cyc(hp);
    m_scl = 1'b0;
    cyc(hp);
    write_reg(16'h0BEE, 8'hC3);
    cyc(10);
    check("t5_q_empty", exp_q.size(), 32'd0);
    check("t5_rd_addr", {16'b0, rd_addr}, 32'h0BEF);

    // Back-to-back register writes at the shortest legal SCL phases
    hp = 6;
    q = 5;
    w0 = wr_cnt;
    for (int k = 0; k < 160; k++) begin
      r = $urandom;
      write_reg(r[15:0], r[23:16]);
    end
    cyc(10);
    check("t6_wr_count", wr_cnt - w0, 32'd160);
    check("t6_q_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
